axis_rr_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one AXI-Stream output among NUM_PORTS AXI-Stream inputs. A grant is held for a whole packet, from grant until the beat carrying tlast is accepted. The block sits between the per-port ingress streams and the single router egress. Downstream backpressure, including the random or fixed tready stalls applied by the slave BFM, passes straight back to the granted input.

---
 rtl/axis_pkg.sv | 18 +
 rtl/rr_priority_select.sv | 28 ++
 rtl/axis_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream arbitration blocks.
package axis_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Index width that never collapses to zero bits for a single port.
  function automatic int clog2_min1(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority search: first asserted request at or after ptr, wrapping around.
module rr_priority_select
  import axis_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = clog2_min1(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     idx,
  output logic                 found
);

  int pos_s;

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos_s = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      pos_s = (int'(ptr) + k) % NUM_PORTS;
      idx   = req[pos_s] ? IDX_W'(pos_s) : idx;
      found = found | req[pos_s];
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS AXI-Stream inputs share one output,
// holding each grant until the tlast beat is accepted.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int TDATA_WIDTH = 32,
  parameter int NUM_PORTS   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [clog2_min1(NUM_PORTS)-1:0] grant_id,
  output logic                             busy
);

  localparam int GID_W = clog2_min1(NUM_PORTS);

  arb_state_e       state_q, state_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             busy_q;
  logic [GID_W-1:0] sel_idx_s;
  logic             sel_found_s;
  logic [TDATA_WIDTH-1:0] g_data_s;
  logic             g_last_s;
  logic             g_valid_s;
  logic             pkt_end_s;

  rr_priority_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (GID_W)
  ) u_sel (
    .req   (s_axis_tvalid),
    .ptr   (rr_ptr_q),
    .idx   (sel_idx_s),
    .found (sel_found_s)
  );

  // Select the granted input's stream signals.
  always_comb begin
    g_data_s  = '0;
    g_last_s  = 1'b0;
    g_valid_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      g_data_s  = (GID_W'(i) == grant_q) ? s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH] : g_data_s;
      g_last_s  = (GID_W'(i) == grant_q) ? s_axis_tlast[i]  : g_last_s;
      g_valid_s = (GID_W'(i) == grant_q) ? s_axis_tvalid[i] : g_valid_s;
    end
  end

  // Egress forward and per-port ready return; everything quiet outside BUSY.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q == BUSY) begin
      m_axis_tdata  = g_data_s;
      m_axis_tlast  = g_last_s;
      m_axis_tvalid = g_valid_s;
      for (int i = 0; i < NUM_PORTS; i++) begin
        s_axis_tready[i] = m_axis_tready & (GID_W'(i) == grant_q);
      end
    end else begin
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
    end
  end

  assign pkt_end_s = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Arbitration FSM; the pointer moves only when a packet completes.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_found_s) begin
          state_d = BUSY;
          grant_d = sel_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (pkt_end_s) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == GID_W'(NUM_PORTS - 1)) ? '0 : grant_q + GID_W'(1);
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= (state_d == BUSY);
    end
  end

  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: a 4-port instance plus a 1-port pass-through instance.
module tb_axis_rr_arbiter;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] s_tdata;
  logic [3:0]   s_tlast, s_tvalid, s_tready;
  logic [31:0]  m_tdata;
  logic         m_tlast, m_tvalid, m_tready;
  logic [1:0]   grant_id;
  logic         busy;

  logic [31:0]  s1_tdata, m1_tdata;
  logic         s1_tlast, s1_tvalid, s1_tready;
  logic         m1_tlast, m1_tvalid, m1_tready;
  logic         grant1;
  logic         busy1;

  beat_t src_q [4][$];
  beat_t exp_q [$];
  beat_t src1_q [$];
  beat_t exp1_q [$];
  logic [3:0] hold;
  logic [3:0] src_fire;
  logic       src1_fire;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int bp_mode = 0;
  int stall = 0;
  bit sink_fire = 1'b0;
  bit gap_en = 1'b0;
  bit have_prev = 1'b0;
  bit prev_last = 1'b0;
  int prev_cyc = 0;
  bit have1 = 1'b0;
  int prev1 = 0;

  axis_rr_arbiter #(.TDATA_WIDTH(32), .NUM_PORTS(4)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .grant_id(grant_id), .busy(busy)
  );

  axis_rr_arbiter #(.TDATA_WIDTH(32), .NUM_PORTS(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s1_tdata), .s_axis_tlast(s1_tlast), .s_axis_tvalid(s1_tvalid), .s_axis_tready(s1_tready),
    .m_axis_tdata(m1_tdata), .m_axis_tlast(m1_tlast), .m_axis_tvalid(m1_tvalid), .m_axis_tready(m1_tready),
    .grant_id(grant1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic src_pkt(input int p, input int len, input logic [31:0] base);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = base + 32'(i);
      b.l = (i == len - 1);
      src_q[p].push_back(b);
    end
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    exp_q.push_back(b);
  endtask

  task automatic exp_pkt(input int len, input logic [31:0] base);
    for (int i = 0; i < len; i++) exp_beat(base + 32'(i), i == len - 1);
  endtask

  task automatic configure_backpressure(input int n);
    bp_mode = n;
  endtask

  task automatic wait_fire(input int bound, input string name, input bit need_last);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_tvalid && m_tready && (m_tlast || !need_last)) && n < bound);
    chk(name, m_tvalid & m_tready & (m_tlast | !need_last), 1);
  endtask

  task automatic drain(input int bound, input string name);
    int n = 0;
    while ((exp_q.size() > 0 || exp1_q.size() > 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, exp_q.size() + exp1_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int p = 0; p < 4; p++) src_q[p].delete();
    hold = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Source BFMs: present the queue head, pop after an accepted beat.
  initial begin
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; hold = '0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        if (src_fire[p] && src_q[p].size() > 0) src_q[p].delete(0);
        if (src_q[p].size() > 0 && !hold[p]) begin
          s_tvalid[p] = 1'b1;
          s_tdata[p*32 +: 32] = src_q[p][0].d;
          s_tlast[p] = src_q[p][0].l;
        end else begin
          s_tvalid[p] = 1'b0;
          s_tdata[p*32 +: 32] = '0;
          s_tlast[p] = 1'b0;
        end
      end
      if (src1_fire && src1_q.size() > 0) src1_q.delete(0);
      s1_tvalid = (src1_q.size() > 0);
      s1_tdata  = (src1_q.size() > 0) ? src1_q[0].d : 32'd0;
      s1_tlast  = (src1_q.size() > 0) ? src1_q[0].l : 1'b0;
    end
  end

  // Sink BFM with optional stalls after each accepted beat.
  initial begin
    m_tready = 1'b1;
    m1_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (sink_fire) stall = (bp_mode < 0) ? int'($urandom_range(9, 0)) : bp_mode;
      if (stall > 0) begin
        m_tready = 1'b0;
        stall--;
      end else begin
        m_tready = 1'b1;
      end
    end
  end

  // Monitors: compare each accepted egress beat against the scoreboards.
  initial begin
    beat_t e;
    src_fire = '0;
    src1_fire = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      src_fire  = s_tvalid & s_tready;
      src1_fire = s1_tvalid & s1_tready;
      sink_fire = m_tvalid & m_tready;
      if (sink_fire) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: actual=%0h required=none", m_tdata);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_tdata, e.d);
          chk("beat_last", m_tlast, e.l);
          if (gap_en && have_prev) chk("beat_gap", cyc - prev_cyc, prev_last ? 2 : 1);
        end
        have_prev = 1'b1;
        prev_cyc  = cyc;
        prev_last = m_tlast;
      end
      if (m1_tvalid && m1_tready) begin
        if (exp1_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL n1_unexpected_beat: actual=%0h required=none", m1_tdata);
        end else begin
          e = exp1_q.pop_front();
          chk("n1_data", m1_tdata, e.d);
          chk("n1_last", m1_tlast, e.l);
          if (have1) chk("n1_gap", cyc - prev1, 2);
        end
        have1 = 1'b1;
        prev1 = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    beat_t b;
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_busy_n1", busy1, 0);

    // Single port, 3-beat packet, no backpressure.
    exp_pkt(3, 32'h0000_00A0);
    src_pkt(0, 3, 32'h0000_00A0);
    wait_fire(20, "t1_tlast_seen", 1'b1);
    chk("t1_grant", grant_id, 0);
    @(negedge clk);
    chk("t1_idle_after", busy, 0);
    chk("t1_grant_hold", grant_id, 0);
    // Pointer now 1: port 1 must beat port 0.
    src_pkt(0, 1, 32'h0000_00B0);
    src_pkt(1, 1, 32'h0000_01B0);
    exp_pkt(1, 32'h0000_01B0);
    exp_pkt(1, 32'h0000_00B0);
    drain(50, "t1_drain");

    // All four ports with 2-beat packets, port 0 twice.
    do_reset();
    gap_en = 1'b1;
    have_prev = 1'b0;
    for (int p = 0; p < 4; p++) src_pkt(p, 2, 32'h2000 + 32'(p * 16));
    src_pkt(0, 2, 32'h2008);
    exp_pkt(2, 32'h2000);
    exp_pkt(2, 32'h2010);
    exp_pkt(2, 32'h2020);
    exp_pkt(2, 32'h2030);
    exp_pkt(2, 32'h2008);
    drain(100, "t2_drain");
    gap_en = 1'b0;

    // Port 2 under random backpressure.
    configure_backpressure(-1);
    src_pkt(2, 4, 32'h3000);
    src_pkt(2, 4, 32'h3100);
    exp_pkt(4, 32'h3000);
    exp_pkt(4, 32'h3100);
    n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      @(negedge clk);
      n++;
      chk("t3_tready", s_tready, (busy && m_tready) ? 4'b0100 : 4'b0000);
    end
    chk("t3_drain", exp_q.size(), 0);
    configure_backpressure(0);
    repeat (12) @(negedge clk);

    // Granted port 1 stalls mid-packet while port 3 requests.
    do_reset();
    src_pkt(1, 3, 32'h4100);
    exp_pkt(3, 32'h4100);
    exp_pkt(2, 32'h4300);
    wait_fire(20, "t4_first_beat", 1'b0);
    hold[1] = 1'b1;
    src_pkt(3, 2, 32'h4300);
    repeat (5) begin
      @(negedge clk);
      chk("t4_mvalid_low", m_tvalid, 0);
      chk("t4_grant_held", grant_id, 1);
    end
    hold[1] = 1'b0;
    drain(50, "t4_drain");

    // Reset during the second beat of a 4-beat packet.
    do_reset();
    src_pkt(0, 4, 32'h5000);
    exp_beat(32'h5000, 1'b0);
    exp_beat(32'h5001, 1'b0);
    wait_fire(20, "t5_first_beat", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    src_q[0].delete();
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_tready", s_tready, 0);
    chk("t5_grant", grant_id, 0);
    chk("t5_mvalid", m_tvalid, 0);
    src_pkt(1, 1, 32'h5100);
    exp_pkt(1, 32'h5100);
    @(negedge clk);
    chk("t5_req_idle", busy, 0);
    @(negedge clk);
    chk("t5_new_busy", busy, 1);
    chk("t5_new_grant", grant_id, 1);
    chk("t5_new_tready", s_tready, 4'b0010);
    drain(20, "t5_drain");

    // Single-port instance, back-to-back single-beat packets.
    for (int i = 0; i < 4; i++) begin
      b.d = 32'h6000 + 32'(i);
      b.l = 1'b1;
      src1_q.push_back(b);
      exp1_q.push_back(b);
    end
    drain(50, "t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
